// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types and constants for the RSA key sequencer
// Purpose: FSM state encoding, key-width derivation and channel indices used by
//          rsa_key_sequencer and rsa_rr_arb2.
// Ports:   none (package).
package rsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_KG_RST     = 3'd1,
        ST_KG_WAIT    = 3'd2,
        ST_READY      = 3'd3,
        ST_EXEC_START = 3'd4,
        ST_EXEC_WAIT  = 3'd5,
        ST_RESP       = 3'd6
    } seq_state_e;

    localparam int CH_ENC = 0;
    localparam int CH_DEC = 1;

    // Modulus and keys are twice the prime width (n = p*q).
    function automatic int kw_of(input int width);
        return 2 * width;
    endfunction

    function automatic logic [1:0] ch_onehot(input logic ch);
        logic [1:0] oh;
        oh = 2'b00;
        oh[ch ? CH_DEC : CH_ENC] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rsa_rr_arb2.sv
// rtl/rsa_rr_arb2.sv - two-way round-robin arbiter
// Purpose: picks one requester; on a tie the channel that was not granted last wins.
// Ports:   req[1:0]   in   per-channel request
//          last       in   index of the most recently granted channel
//          grant[1:0] out  one-hot grant (zero when no request)
module rsa_rr_arb2
    import rsa_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[CH_ENC] && req[CH_DEC]) begin
            grant = (last == 1'(CH_DEC)) ? ch_onehot(1'(CH_ENC)) : ch_onehot(1'(CH_DEC));
        end else if (req[CH_ENC]) begin
            grant = ch_onehot(1'(CH_ENC));
        end else if (req[CH_DEC]) begin
            grant = ch_onehot(1'(CH_DEC));
        end
    end

endmodule

// File: rtl/rsa_key_sequencer.sv
// rtl/rsa_key_sequencer.sv - RSA key generation sequencer and shared modexp front end
// Purpose: runs the key-inverter datapath (p/q, reset pulse, wait for finish, latch
//          n/e/d), then serves encrypt (ch0) and decrypt (ch1) requests on one
//          modular-exponentiation engine with round-robin arbitration.
// Option:  RSA_SEQ_TIMEOUT_EN enables a watchdog on KG_WAIT and EXEC_WAIT; without it
//          the waits are unbounded and me_abort / kg_err are tied low.
// Ports:   clk, reset (sync, active-high)
//          keygen_go, p, q           key generation request and primes
//          kg_p, kg_q, kg_reset      inverter drive; kg_finish, kg_e, kg_d inverter result
//          keys_valid, kg_err        key status; n_out, e_out, d_out latched keys
//          req_valid/req_ready/req_msg       request handshake (ch0 in low half)
//          me_start, me_base, me_exp, me_mod engine operands; me_done, me_result back
//          me_abort                          engine abort pulse
//          resp_valid/resp_ready/resp_data/resp_err  response handshake
module rsa_key_sequencer
    import rsa_pkg::*;
#(
    parameter  int WIDTH          = 32,
    parameter  int TIMEOUT_CYCLES = 65536,
    localparam int KW             = kw_of(WIDTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            keygen_go,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] kg_p,
    output logic [WIDTH-1:0] kg_q,
    output logic            kg_reset,
    input  logic            kg_finish,
    input  logic [KW-1:0]   kg_e,
    input  logic [KW-1:0]   kg_d,
    output logic            keys_valid,
    output logic            kg_err,
    output logic [KW-1:0]   n_out,
    output logic [KW-1:0]   e_out,
    output logic [KW-1:0]   d_out,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*KW-1:0] req_msg,
    output logic            me_start,
    output logic [KW-1:0]   me_base,
    output logic [KW-1:0]   me_exp,
    output logic [KW-1:0]   me_mod,
    input  logic            me_done,
    input  logic [KW-1:0]   me_result,
    output logic            me_abort,
    output logic [1:0]      resp_valid,
    input  logic [1:0]      resp_ready,
    output logic [KW-1:0]   resp_data,
    output logic            resp_err
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] kg_p_q, kg_p_d;
    logic [WIDTH-1:0] kg_q_q, kg_q_d;
    logic             kg_reset_q, kg_reset_d;
    logic             keys_valid_q, keys_valid_d;
    logic [KW-1:0]    n_q, n_d;
    logic [KW-1:0]    e_q, e_d;
    logic [KW-1:0]    d_q, d_d;
    logic             me_start_q, me_start_d;
    logic [KW-1:0]    me_base_q, me_base_d;
    logic [KW-1:0]    me_exp_q, me_exp_d;
    logic [KW-1:0]    me_mod_q, me_mod_d;
    logic [1:0]       resp_valid_q, resp_valid_d;
    logic [KW-1:0]    resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;
    logic             ch_q, ch_d;
    logic             last_q, last_d;

    logic [1:0]       grant;
    logic             req_open;
    logic [KW-1:0]    sel_msg;

`ifdef RSA_SEQ_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            me_abort_q, me_abort_d;
    logic            kg_err_q, kg_err_d;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    rsa_rr_arb2 u_arb (
        .req   (req_valid),
        .last  (last_q),
        .grant (grant)
    );

    // Grants open only in READY, and a simultaneous keygen_go takes precedence.
    assign req_open  = (state_q == ST_READY) && !keygen_go;
    assign req_ready = req_open ? grant : 2'b00;
    assign sel_msg   = grant[CH_DEC] ? req_msg[CH_DEC*KW +: KW] : req_msg[CH_ENC*KW +: KW];

    always_comb begin
        state_d      = state_q;
        kg_p_d       = kg_p_q;
        kg_q_d       = kg_q_q;
        kg_reset_d   = 1'b0;
        keys_valid_d = keys_valid_q;
        n_d          = n_q;
        e_d          = e_q;
        d_d          = d_q;
        me_start_d   = 1'b0;
        me_base_d    = me_base_q;
        me_exp_d     = me_exp_q;
        me_mod_d     = me_mod_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        ch_d         = ch_q;
        last_d       = last_q;
`ifdef RSA_SEQ_TIMEOUT_EN
        wd_cnt_d     = '0;
        me_abort_d   = 1'b0;
        kg_err_d     = kg_err_q;
`endif

        case (state_q)
            ST_IDLE, ST_READY: begin
                if (keygen_go) begin
                    kg_p_d       = p;
                    kg_q_d       = q;
                    n_d          = KW'(p) * KW'(q);
                    keys_valid_d = 1'b0;
                    kg_reset_d   = 1'b1;
                    state_d      = ST_KG_RST;
`ifdef RSA_SEQ_TIMEOUT_EN
                    kg_err_d     = 1'b0;
`endif
                end else if (|req_ready) begin
                    ch_d = grant[CH_DEC];
                    if (sel_msg >= n_q) begin
                        // Out-of-range message never reaches the engine.
                        resp_valid_d = ch_onehot(grant[CH_DEC]);
                        resp_data_d  = '0;
                        resp_err_d   = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        me_start_d = 1'b1;
                        me_base_d  = sel_msg;
                        me_mod_d   = n_q;
                        me_exp_d   = grant[CH_DEC] ? d_q : e_q;
                        state_d    = ST_EXEC_START;
                    end
                end
            end
            ST_KG_RST: begin
                state_d = ST_KG_WAIT;
            end
            ST_KG_WAIT: begin
`ifdef RSA_SEQ_TIMEOUT_EN
                wd_cnt_d = wd_cnt_q + 1'b1;
`endif
                if (kg_finish) begin
                    e_d          = kg_e;
                    d_d          = kg_d;
                    keys_valid_d = 1'b1;
                    state_d      = ST_READY;
                end
`ifdef RSA_SEQ_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    kg_err_d     = 1'b1;
                    keys_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
`endif
            end
            ST_EXEC_START: begin
                state_d = ST_EXEC_WAIT;
            end
            ST_EXEC_WAIT: begin
`ifdef RSA_SEQ_TIMEOUT_EN
                wd_cnt_d = wd_cnt_q + 1'b1;
`endif
                if (me_done) begin
                    resp_valid_d = ch_onehot(ch_q);
                    resp_data_d  = me_result;
                    resp_err_d   = 1'b0;
                    state_d      = ST_RESP;
                end
`ifdef RSA_SEQ_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    me_abort_d   = 1'b1;
                    resp_valid_d = ch_onehot(ch_q);
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    state_d      = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                if (resp_ready[ch_q]) begin
                    resp_valid_d = 2'b00;
                    last_d       = ch_q;
                    state_d      = ST_READY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef RSA_SEQ_TIMEOUT_EN
        // Each wait state starts counting from zero on entry.
        if (state_d != state_q) begin
            wd_cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            kg_p_q       <= '0;
            kg_q_q       <= '0;
            kg_reset_q   <= 1'b0;
            keys_valid_q <= 1'b0;
            n_q          <= '0;
            e_q          <= '0;
            d_q          <= '0;
            me_start_q   <= 1'b0;
            me_base_q    <= '0;
            me_exp_q     <= '0;
            me_mod_q     <= '0;
            resp_valid_q <= 2'b00;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            ch_q         <= 1'b0;
            last_q       <= 1'(CH_DEC);  // so ch0 wins the first tie
`ifdef RSA_SEQ_TIMEOUT_EN
            wd_cnt_q     <= '0;
            me_abort_q   <= 1'b0;
            kg_err_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            kg_p_q       <= kg_p_d;
            kg_q_q       <= kg_q_d;
            kg_reset_q   <= kg_reset_d;
            keys_valid_q <= keys_valid_d;
            n_q          <= n_d;
            e_q          <= e_d;
            d_q          <= d_d;
            me_start_q   <= me_start_d;
            me_base_q    <= me_base_d;
            me_exp_q     <= me_exp_d;
            me_mod_q     <= me_mod_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            ch_q         <= ch_d;
            last_q       <= last_d;
`ifdef RSA_SEQ_TIMEOUT_EN
            wd_cnt_q     <= wd_cnt_d;
            me_abort_q   <= me_abort_d;
            kg_err_q     <= kg_err_d;
`endif
        end
    end

    assign kg_p       = kg_p_q;
    assign kg_q       = kg_q_q;
    assign kg_reset   = kg_reset_q;
    assign keys_valid = keys_valid_q;
    assign n_out      = n_q;
    assign e_out      = e_q;
    assign d_out      = d_q;
    assign me_start   = me_start_q;
    assign me_base    = me_base_q;
    assign me_exp     = me_exp_q;
    assign me_mod     = me_mod_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
`ifdef RSA_SEQ_TIMEOUT_EN
    assign me_abort   = me_abort_q;
    assign kg_err     = kg_err_q;
`else
    assign me_abort   = 1'b0;
    assign kg_err     = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_key_sequencer.sv
// tb/tb_rsa_key_sequencer.sv - directed self-checking bench for rsa_key_sequencer
module tb_rsa_key_sequencer;

    localparam int WIDTH = 32;
    localparam int KW    = 2 * WIDTH;
    localparam int TO    = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            keygen_go;
    logic [WIDTH-1:0] p, q, kg_p, kg_q;
    logic            kg_reset, kg_finish;
    logic [KW-1:0]   kg_e, kg_d;
    logic            keys_valid, kg_err;
    logic [KW-1:0]   n_out, e_out, d_out;
    logic [1:0]      req_valid, req_ready;
    logic [2*KW-1:0] req_msg;
    logic            me_start;
    logic [KW-1:0]   me_base, me_exp, me_mod;
    logic            me_done;
    logic [KW-1:0]   me_result;
    logic            me_abort;
    logic [1:0]      resp_valid, resp_ready;
    logic [KW-1:0]   resp_data;
    logic            resp_err;

    int n_checks = 0;
    int n_fail   = 0;

    rsa_key_sequencer #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .keygen_go  (keygen_go),
        .p          (p),
        .q          (q),
        .kg_p       (kg_p),
        .kg_q       (kg_q),
        .kg_reset   (kg_reset),
        .kg_finish  (kg_finish),
        .kg_e       (kg_e),
        .kg_d       (kg_d),
        .keys_valid (keys_valid),
        .kg_err     (kg_err),
        .n_out      (n_out),
        .e_out      (e_out),
        .d_out      (d_out),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_msg    (req_msg),
        .me_start   (me_start),
        .me_base    (me_base),
        .me_exp     (me_exp),
        .me_mod     (me_mod),
        .me_done    (me_done),
        .me_result  (me_result),
        .me_abort   (me_abort),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int ch);
        return (ch == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic keygen(input logic [WIDTH-1:0] pp, input logic [WIDTH-1:0] qq,
                          input logic [KW-1:0] ee, input logic [KW-1:0] dd,
                          input logic [KW-1:0] exp_n);
        @(negedge clk);
        p = pp; q = qq; keygen_go = 1'b1;
        @(negedge clk);
        keygen_go = 1'b0;
        check("kg_reset_hi", kg_reset, 1);
        check("kg_p", kg_p, pp);
        check("kg_q", kg_q, qq);
        check("n_out", n_out, exp_n);
        check("keys_cleared", keys_valid, 0);
        @(negedge clk);
        check("kg_reset_lo", kg_reset, 0);
        kg_e = ee; kg_d = dd; kg_finish = 1'b1;
        @(negedge clk);
        kg_finish = 1'b0;
        check("keys_valid", keys_valid, 1);
        check("e_out", e_out, ee);
        check("d_out", d_out, dd);
    endtask

    // Presents one request; state must be READY when the following negedge arrives.
    task automatic issue(input int ch, input logic [KW-1:0] msg);
        @(negedge clk);
        req_valid = oh(ch);
        req_msg   = (ch == 1) ? {msg, 64'd0} : {64'd0, msg};
        #1;
        check("req_ready", req_ready, oh(ch));
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    task automatic take_resp(input int ch, input logic [KW-1:0] data, input logic err, input int hold);
        int k;
        k = 0;
        while (resp_valid == 2'b00 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("resp_valid", resp_valid, oh(ch));
        check("resp_data", resp_data, data);
        check("resp_err", resp_err, err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("resp_hold_valid", resp_valid, oh(ch));
            check("resp_hold_data", resp_data, data);
        end
        resp_ready = oh(ch);
        @(negedge clk);
        resp_ready = 2'b00;
        check("resp_drop", resp_valid, 0);
    endtask

    task automatic serve(input int ch, input logic [KW-1:0] base, input logic [KW-1:0] ex,
                         input logic [KW-1:0] result, input int lat, input int hold);
        int k;
        k = 0;
        while (!me_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("me_start", me_start, 1);
        check("me_base", me_base, base);
        check("me_exp", me_exp, ex);
        check("me_mod", me_mod, 3233);
        @(negedge clk);
        check("me_start_pulse", me_start, 0);
        repeat (lat - 1) @(negedge clk);
        me_done = 1'b1; me_result = result;
        @(negedge clk);
        me_done = 1'b0;
        take_resp(ch, result, 1'b0, hold);
    endtask

    initial begin
        int  k;
        bit  saw;
        int  gch;
        reset = 1'b1; keygen_go = 1'b0; p = '0; q = '0; kg_finish = 1'b0;
        kg_e = '0; kg_d = '0; req_valid = 2'b00; req_msg = '0;
        me_done = 1'b0; me_result = '0; resp_ready = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {kg_reset, keys_valid, me_start, resp_valid, resp_err, me_abort, kg_err, req_ready}, 0);
        check("rst_regs", {n_out, me_base, kg_p}, 0);
        reset = 1'b0;

        // Requests before keys exist are never granted.
        @(negedge clk);
        req_valid = 2'b01; req_msg = {64'd0, 64'd65};
        for (int i = 0; i < 3; i++) begin
            #1;
            check("no_keys_ready", req_ready, 0);
            @(negedge clk);
        end
        req_valid = 2'b00;

        keygen(32'd61, 32'd53, 64'd7, 64'd1783, 64'd3233);

        issue(0, 64'd65);
        serve(0, 64'd65, 64'd7, 64'd1317, 2, 0);

        issue(1, 64'd1317);
        serve(1, 64'd1317, 64'd1783, 64'd65, 3, 5);

        // Both channels request continuously; grants must alternate starting at ch0.
        req_msg = {64'd1317, 64'd65};
        @(negedge clk);
        req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            #1;
            k = 0;
            while (req_ready == 2'b00 && k < 20) begin
                @(negedge clk);
                #1;
                k++;
            end
            gch = req_ready[1] ? 1 : 0;
            check("arb_grant", req_ready, oh(g % 2));
            @(negedge clk);
            if (gch == 1) serve(1, 64'd1317, 64'd1783, 64'd65, 1, 0);
            else          serve(0, 64'd65, 64'd7, 64'd1317, 1, 0);
            if (g == 3) req_valid = 2'b00;
        end

        // Message equal to n is rejected without starting the engine.
        @(negedge clk);
        req_valid = 2'b01; req_msg = {64'd0, 64'd3233};
        #1;
        check("err_ready", req_ready, 2'b01);
        saw = 1'b0;
        @(negedge clk);
        req_valid = 2'b00;
        k = 0;
        while (resp_valid == 2'b00 && k < 20) begin
            if (me_start) saw = 1'b1;
            @(negedge clk);
            k++;
        end
        if (me_start) saw = 1'b1;
        check("err_no_start", saw, 0);
        take_resp(0, 64'd0, 1'b1, 0);

        // keygen_go and a request together: keygen wins, no grant.
        @(negedge clk);
        req_valid = 2'b01; req_msg = {64'd0, 64'd65};
        p = 32'd61; q = 32'd53; keygen_go = 1'b1;
        #1;
        check("kg_wins_ready", req_ready, 0);
        @(negedge clk);
        keygen_go = 1'b0; req_valid = 2'b00;
        check("kg_wins_rst", kg_reset, 1);
        check("kg_wins_kv", keys_valid, 0);
        @(negedge clk);
        kg_e = 64'd7; kg_d = 64'd1783; kg_finish = 1'b1;
        @(negedge clk);
        kg_finish = 1'b0;
        check("kg_wins_kv2", keys_valid, 1);

`ifdef RSA_SEQ_TIMEOUT_EN
        // Silent engine: abort pulse and an error response after the watchdog.
        issue(0, 64'd65);
        check("to_start", me_start, 1);
        k = 0;
        while (!me_abort && k < TO + 20) begin
            @(negedge clk);
            k++;
        end
        check("to_abort", me_abort, 1);
        check("to_resp_valid", resp_valid, 2'b01);
        check("to_resp_err", resp_err, 1);
        @(negedge clk);
        check("to_abort_pulse", me_abort, 0);
        resp_ready = 2'b01;
        @(negedge clk);
        resp_ready = 2'b00;
        check("to_resp_drop", resp_valid, 0);

        // Silent inverter: sticky kg_err and keys dropped.
        @(negedge clk);
        p = 32'd61; q = 32'd53; keygen_go = 1'b1;
        @(negedge clk);
        keygen_go = 1'b0;
        k = 0;
        while (!kg_err && k < TO + 20) begin
            @(negedge clk);
            k++;
        end
        check("kg_to_err", kg_err, 1);
        check("kg_to_keys", keys_valid, 0);
        keygen(32'd61, 32'd53, 64'd7, 64'd1783, 64'd3233);
        check("kg_err_cleared", kg_err, 0);
`endif

        // Reset during EXEC_WAIT abandons everything.
        issue(0, 64'd65);
        check("rst_mid_start", me_start, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_ctrl", {kg_reset, keys_valid, me_start, resp_valid, resp_err, me_abort, kg_err, req_ready}, 0);
        check("rst_mid_regs", {n_out, e_out, me_base, me_exp}, 0);
        reset = 1'b0;
        me_done = 1'b1; me_result = 64'd1317;
        @(negedge clk);
        me_done = 1'b0;
        @(negedge clk);
        check("rst_no_resp", resp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
